led_run_module: RTL and testbench
=================================

# led_run_module

Running-light controller that sits directly downstream of the LED timing stage. It consumes that stage's periodic 1-bit pulse window as a step strobe and advances an N-bit LED pattern once per strobe. Four patterns are supported: shift-left, shift-right, ping-pong and all-flash, with a pause control. It drives the board LEDs and emits a wrap strobe so that further stages can be chained.

## Interface
- LED_NUM, default 4: number of LEDs (pattern width); legal values 2..16.
- CLK  input  1  system clock; all logic is on the rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- Step_In  input  1  step window from the upstream timing stage. It is registered in the CLK domain and may stay high for many cycles. Only its rising edge counts.
- Mode_In  input  2  00 shift-left, 01 shift-right, 10 ping-pong, 11 all-flash. Sampled on each step event.
- Pause_In  input  1  level; while high, step events are ignored.
- LED_Out  output  LED_NUM  current LED pattern, registered.
- Wrap_Out  output  1  one-cycle strobe marking completion of a pattern cycle, registered.

## Operation
- **Edge detect**
  - rStep_d <= Step_In every cycle, in all states.
  - step_evt = Step_In & ~rStep_d.
  - A Step_In held high yields exactly one event.
- **States**
  - IDLE: reset state. LED_Out = 0. The first step_evt with Pause_In low loads LED_Out = 1 (LSB one-hot), forces dir = up and moves to RUN. Pause_In is ignored in IDLE.
  - RUN: each step_evt applies the mode rule below. Pause_In high moves to PAUSE.
  - PAUSE: LED_Out and dir are held and step_evt is discarded. Pause_In low returns to RUN. There is no catch-up for events missed while paused.
- **Reload rule (RUN, shift or ping-pong modes)**
  - Applies on a step_evt when LED_Out is not one-hot (0 or all-ones, e.g. after flash mode).
  - next = 1 and dir = up, regardless of the mode rule. No Wrap_Out is issued.
- **Mode 00, shift-left**
  - next = {LED[N-2:0], LED[N-1]}.
  - Wrap_Out fires when the MSB rotates to the LSB.
- **Mode 01, shift-right**
  - next = {LED[0], LED[N-1:1]}.
  - Wrap_Out fires when the LSB rotates to the MSB.
- **Mode 10, ping-pong** (dir register, reset = up)
  - Up: shift left; at the MSB, set dir = down and move to bit N-2 in the same step.
  - Down: shift right; at the LSB, set dir = up, move to bit 1 and fire Wrap_Out.
  - The end positions are never repeated.
  - dir is kept across mode changes unless a reload occurs.
- **Mode 11, all-flash**
  - next = (LED_Out == all-ones) ? 0 : all-ones.
  - Wrap_Out fires on each ones→0 transition.
- **Pause priority:** if Pause_In is high in the same cycle as step_evt (RUN state), pause wins and the event is dropped.
- **Wrap_Out** is high for exactly one cycle, coincident with the LED_Out update it marks. At all other times it is 0.

## Timing
- **Reset (asynchronous):** LED_Out = 0, Wrap_Out = 0, state = IDLE, dir = up, rStep_d = 0. These take effect immediately, mid-operation included, with no clock required.
- **Step latency:** Step_In goes high after edge k-1 and is sampled high at edge k with rStep_d = 0. LED_Out and Wrap_Out update at edge k. This is 1 cycle from Step_In rising.
- **Pause latency:** Pause_In sampled high at edge k blocks any step_evt at edge k. The state is PAUSE after edge k.
- **Minimum step spacing:** step events may be as close as every 2 cycles (high one cycle, low one cycle); each is honoured.
- **Mode changes:** Mode_In may change in any cycle. Only its value at the step_evt edge matters.

## Test plan
- Reset, then one Step_In pulse: LED_Out = 0000 and Wrap_Out = 0 until the edge after the rise, then LED_Out = 0001.
- Mode 00, five more pulses: LED_Out goes 0010, 0100, 1000, 0001 (Wrap_Out = 1 for one cycle), 0010.
- Mode 10 from 0001, eight pulses: LED_Out goes 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100. Wrap_Out fires only on the 0010→0001 transition (6th step).
- Step_In held high for 20 cycles: exactly one advance. Pause_In high across three pulses: LED_Out is unchanged. Pause_In and the Step_In rise in the same cycle: no advance.
- Mode 11 from 0100: LED_Out goes 1111, 0000 (Wrap_Out), 1111. Then switch to 01 and pulse: LED_Out = 0001 with no Wrap_Out. Pulse again: LED_Out = 1000 with Wrap_Out.
- RSTn asserted low mid-run, with no clock edge: LED_Out = 0000 and Wrap_Out = 0 immediately. After release, IDLE needs a fresh Step_In rise to load 0001.

Source files
------------

// File: rtl/led_run_module.sv
// Running-light controller: advances an LED_NUM-bit pattern on each rising edge of the
// upstream step window, with shift-left/right, ping-pong and flash modes plus pause.
module led_run_module #(
  parameter int unsigned LED_NUM = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Step_In,
  input  logic [1:0]         Mode_In,
  input  logic               Pause_In,
  output logic [LED_NUM-1:0] LED_Out,
  output logic               Wrap_Out
);

  localparam int unsigned W = LED_NUM;
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] LSB_ONLY = W'(1);
  localparam logic [1:0]   MODE_SHL   = 2'b00;
  localparam logic [1:0]   MODE_SHR   = 2'b01;
  localparam logic [1:0]   MODE_PING  = 2'b10;
  localparam logic [1:0]   MODE_FLASH = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   led_nxt;
  logic           wrap_nxt;
  logic           dir_up, dir_nxt;
  logic           step_d;
  logic           step_evt;
  logic           is_onehot;

  assign step_evt  = Step_In & ~step_d;
  assign is_onehot = (LED_Out != '0) && ((LED_Out & (LED_Out - W'(1))) == '0);

  // State, pattern, direction and edge-detect registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      LED_Out  <= '0;
      Wrap_Out <= 1'b0;
      dir_up   <= 1'b1;
      step_d   <= 1'b0;
    end else begin
      state    <= state_nxt;
      LED_Out  <= led_nxt;
      Wrap_Out <= wrap_nxt;
      dir_up   <= dir_nxt;
      step_d   <= Step_In;
    end
  end

  // Next-state and next-pattern logic
  always_comb begin
    state_nxt = state;
    led_nxt   = LED_Out;
    wrap_nxt  = 1'b0;
    dir_nxt   = dir_up;
    unique case (state)
      IDLE: begin
        if (step_evt && !Pause_In) begin
          led_nxt   = LSB_ONLY;
          dir_nxt   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (Pause_In) begin
          state_nxt = PAUSE;
        end else if (step_evt) begin
          // Shift modes restart from the LSB when the pattern is not a single lit LED
          if (Mode_In != MODE_FLASH && !is_onehot) begin
            led_nxt = LSB_ONLY;
            dir_nxt = 1'b1;
          end else begin
            unique case (Mode_In)
              MODE_SHL: begin
                led_nxt  = {LED_Out[W-2:0], LED_Out[W-1]};
                wrap_nxt = LED_Out[W-1];
              end
              MODE_SHR: begin
                led_nxt  = {LED_Out[0], LED_Out[W-1:1]};
                wrap_nxt = LED_Out[0];
              end
              MODE_PING: begin
                // Direction flips on arrival at an end, so no end position is shown twice
                if (dir_up) begin
                  if (LED_Out[W-1]) begin
                    led_nxt = LED_Out >> 1;
                    dir_nxt = 1'b0;
                  end else begin
                    led_nxt = LED_Out << 1;
                    if (LED_Out[W-2]) dir_nxt = 1'b0;
                  end
                end else begin
                  if (LED_Out[0]) begin
                    led_nxt = LED_Out << 1;
                    dir_nxt = 1'b1;
                  end else begin
                    led_nxt = LED_Out >> 1;
                    if (LED_Out[1]) begin
                      dir_nxt  = 1'b1;
                      wrap_nxt = 1'b1;
                    end
                  end
                end
              end
              default: begin
                if (LED_Out == ALL_ONES) begin
                  led_nxt  = '0;
                  wrap_nxt = 1'b1;
                end else begin
                  led_nxt = ALL_ONES;
                end
              end
            endcase
          end
        end
      end
      PAUSE: begin
        if (!Pause_In) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_run_module.sv
// Self-checking bench for led_run_module: directed pulse table, multi-cycle corner
// sequences, then random stimulus against an index-based reference model.
module tb_led_run_module;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         Step_In;
  logic [1:0]   Mode_In;
  logic         Pause_In;
  logic [N-1:0] LED_Out;
  logic         Wrap_Out;

  int n_vec = 0;
  int n_err = 0;

  led_run_module #(.LED_NUM(N)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Step_In  (Step_In),
    .Mode_In  (Mode_In),
    .Pause_In (Pause_In),
    .LED_Out  (LED_Out),
    .Wrap_Out (Wrap_Out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]   mode;
    logic [N-1:0] led;
    logic         wrap;
  } vec_t;

  vec_t tbl [20];

  // Reference model: pattern tracked as a lit-LED index with plain modular arithmetic
  int           m_state;   // 0 idle, 1 run, 2 pause
  logic         m_prev;
  logic [N-1:0] m_led;
  logic         m_up;
  logic         m_wrap;

  function automatic int pos_of(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] led_at(int i);
    logic [N-1:0] one;
    one = N'(1);
    return one << i;
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = 1'b0; m_led = '0; m_up = 1'b1; m_wrap = 1'b0;
  endtask

  task automatic model_apply(logic [1:0] m);
    int p, np;
    p  = pos_of(m_led);
    np = p;
    if (m != 2'b11 && $countones(m_led) != 1) begin
      m_led = led_at(0);
      m_up  = 1'b1;
      return;
    end
    case (m)
      2'b00: begin np = (p + 1) % N;     m_wrap = (p == N - 1); m_led = led_at(np); end
      2'b01: begin np = (p + N - 1) % N; m_wrap = (p == 0);     m_led = led_at(np); end
      2'b10: begin
        if (m_up) begin
          if (p == N - 1) begin np = N - 2; m_up = 1'b0; end
          else begin np = p + 1; if (np == N - 1) m_up = 1'b0; end
        end else begin
          if (p == 0) begin np = 1; m_up = 1'b1; end
          else begin
            np = p - 1;
            if (np == 0) begin m_up = 1'b1; m_wrap = 1'b1; end
          end
        end
        m_led = led_at(np);
      end
      default: begin
        if (m_led == {N{1'b1}}) begin m_led = '0; m_wrap = 1'b1; end
        else m_led = {N{1'b1}};
      end
    endcase
  endtask

  task automatic model_edge(logic s, logic [1:0] m, logic p);
    logic evt;
    evt    = s && !m_prev;
    m_prev = s;
    m_wrap = 1'b0;
    case (m_state)
      0: if (evt && !p) begin m_led = led_at(0); m_up = 1'b1; m_state = 1; end
      1: if (p) m_state = 2; else if (evt) model_apply(m);
      default: if (!p) m_state = 1;
    endcase
  endtask

  task automatic chk(string nm, logic [N-1:0] el, logic ew);
    n_vec++;
    if (LED_Out !== el || Wrap_Out !== ew) begin
      n_err++;
      $display("FAIL %s: LED_Out=%b Wrap_Out=%b, expected LED_Out=%b Wrap_Out=%b",
               nm, LED_Out, Wrap_Out, el, ew);
    end
  endtask

  // Drive inputs at a falling edge, then advance to the next falling edge
  task automatic cyc(logic s, logic [1:0] m, logic p);
    Step_In = s; Mode_In = m; Pause_In = p;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic pulse(string nm, logic [1:0] m, logic [N-1:0] el, logic ew);
    cyc(1'b1, m, 1'b0);
    chk(nm, el, ew);
    cyc(1'b0, m, 1'b0);
    chk({nm, "_low"}, el, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{2'b00, 4'b0001, 1'b0};
    tbl[1]  = '{2'b00, 4'b0010, 1'b0};
    tbl[2]  = '{2'b00, 4'b0100, 1'b0};
    tbl[3]  = '{2'b00, 4'b1000, 1'b0};
    tbl[4]  = '{2'b00, 4'b0001, 1'b1};
    tbl[5]  = '{2'b00, 4'b0010, 1'b0};
    tbl[6]  = '{2'b01, 4'b0001, 1'b0};
    tbl[7]  = '{2'b10, 4'b0010, 1'b0};
    tbl[8]  = '{2'b10, 4'b0100, 1'b0};
    tbl[9]  = '{2'b10, 4'b1000, 1'b0};
    tbl[10] = '{2'b10, 4'b0100, 1'b0};
    tbl[11] = '{2'b10, 4'b0010, 1'b0};
    tbl[12] = '{2'b10, 4'b0001, 1'b1};
    tbl[13] = '{2'b10, 4'b0010, 1'b0};
    tbl[14] = '{2'b10, 4'b0100, 1'b0};
    tbl[15] = '{2'b11, 4'b1111, 1'b0};
    tbl[16] = '{2'b11, 4'b0000, 1'b1};
    tbl[17] = '{2'b11, 4'b1111, 1'b0};
    tbl[18] = '{2'b01, 4'b0001, 1'b0};
    tbl[19] = '{2'b01, 4'b1000, 1'b1};

    RSTn = 1'b0; Step_In = 1'b0; Mode_In = 2'b00; Pause_In = 1'b0;
    @(negedge CLK);
    chk("reset", 4'b0000, 1'b0);
    RSTn = 1'b1;
    cyc(1'b0, 2'b00, 1'b0);
    chk("idle", 4'b0000, 1'b0);
    Step_In = 1'b1;
    #2 chk("pre_edge", 4'b0000, 1'b0);
    @(negedge CLK);
    Step_In = 1'b0;

    // The pulse above already loaded the pattern; restart cleanly for the table
    RSTn = 1'b0;
    #1 RSTn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 20; i++) pulse($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].led, tbl[i].wrap);

    // Held step window gives exactly one advance (pattern 1000, mode 01)
    cyc(1'b1, 2'b01, 1'b0);
    chk("hold_first", 4'b0100, 1'b0);
    for (int i = 0; i < 19; i++) cyc(1'b1, 2'b01, 1'b0);
    chk("hold_end", 4'b0100, 1'b0);
    cyc(1'b0, 2'b01, 1'b0);

    // Pause across three pulses
    cyc(1'b0, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'b01, 1'b1);
      chk("paused_pulse", 4'b0100, 1'b0);
      cyc(1'b0, 2'b01, 1'b1);
    end
    cyc(1'b0, 2'b01, 1'b0);
    chk("unpause", 4'b0100, 1'b0);

    // Pause and step rise in the same cycle: event dropped
    cyc(1'b1, 2'b01, 1'b1);
    chk("pause_same_cycle", 4'b0100, 1'b0);
    cyc(1'b0, 2'b01, 1'b0);
    chk("resume", 4'b0100, 1'b0);
    pulse("after_pause1", 2'b01, 4'b0010, 1'b0);
    pulse("after_pause2", 2'b01, 4'b0001, 1'b0);

    // Asynchronous reset while Wrap_Out is high
    Step_In = 1'b1; Mode_In = 2'b01; Pause_In = 1'b0;
    @(posedge CLK);
    #1 chk("wrap_before_rst", 4'b1000, 1'b1);
    RSTn = 1'b0;
    #1 chk("async_rst", 4'b0000, 1'b0);
    @(negedge CLK);
    Step_In = 1'b0;
    cyc(1'b0, 2'b00, 1'b0);
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0);
    chk("post_rst_idle", 4'b0000, 1'b0);
    pulse("post_rst_load", 2'b00, 4'b0001, 1'b0);

    // Random stimulus against the reference model
    RSTn = 1'b0;
    model_reset();
    @(negedge CLK);
    RSTn = 1'b1;
    begin
      logic [1:0] m;
      logic       p;
      logic       s;
      m = 2'b00; p = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        s = ($urandom_range(0, 9) < 5);
        if ($urandom_range(0, 7) == 0) m = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 11) == 0) p = ~p;
        cyc(s, m, p);
        model_edge(s, m, p);
        chk($sformatf("rand%0d", i), m_led, m_wrap);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
